fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin burst arbiter that shares the async FIFO write port among NUM_REQ write-domain requesters; runs entirely in the wclk domain.
- Per-requester valid/ready handshake in; registered write_enable/wdata/afull_value out to the FIFO write side.
- Throttles from wr_level so the FIFO never sees a write while full, and the FIFO's overflow flag never fires.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, word width
- FIFO_DEPTH, 32, FIFO capacity in words (must match wr_level range)
- MAX_BURST, 8, max words per grant (1..16)
- AFULL_DEFAULT, 20, reset value of afull_value

Ports:
- wclk  in  1  write-domain clock
- hw_rst  in  1  asynchronous active-low reset
- sw_rst  in  1  synchronous abort/flush, active-high
- req  in  NUM_REQ  per-requester valid
- req_data  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks the final word of requester's burst
- gnt  out  NUM_REQ  per-requester ready; word moves when req[i]&&gnt[i]
- afull_cfg  in  5  requested almost-full threshold
- wfull  in  1  FIFO full
- wr_level  in  6  FIFO write-side occupancy
- wdata  out  DATA_W  FIFO write data (registered)
- write_enable  out  1  FIFO write strobe (registered)
- afull_value  out  5  FIFO almost-full threshold (registered)
- owner  out  $clog2(NUM_REQ)  current/last granted requester
- busy  out  1  high while in BURST

Behaviour:
- Reset (hw_rst low, async): state=IDLE, write_enable=0, wdata=0, gnt=0, owner=0, busy=0, afull_value=AFULL_DEFAULT, rr pointer=0 (requester 0 searched first), burst count=0.
- space = !wfull && (wr_level + write_enable < FIFO_DEPTH). The register stage holds at most one in-flight word.
- IDLE:
  - gnt=0.
  - afull_value<=afull_cfg (threshold changes only here, never mid-burst).
  - If any req: pick first asserted req at or after rr pointer (wrapping), owner<=that index, count<=0, go BURST.
  - Arbitration costs one cycle.
- BURST:
  - gnt[owner]=space (combinational); all other gnt=0.
  - Transfer: wdata<=req_data[owner], write_enable<=1, count++.
  - No transfer: write_enable<=0.
  - Exit to IDLE, with rr pointer<=owner+1 mod NUM_REQ, after a transfer where req_last=1 or count reaches MAX_BURST (whichever first; both at once = single exit).
  - Exit the same way if req[owner] is low for a cycle while space is high.
  - space low only stalls: stay in BURST, count held, requester keeps req.
- Latency: req asserted in IDLE at cycle 0 -> gnt at cycle 1 -> write_enable at cycle 2. Back-to-back words in a burst give one write per cycle.
- Burst-to-next-owner gap: 1 IDLE cycle.
- sw_rst=1 at any edge:
  - state=IDLE, write_enable=0, gnt=0, count=0, rr pointer=0.
  - An in-flight registered word is dropped.
  - afull_value and owner are unchanged.
  - sw_rst has priority over a transfer in the same cycle.
- Invariants:
  - write_enable never high while wfull.
  - At most one gnt high.
  - No requester is starved beyond (NUM_REQ-1)*MAX_BURST words of others.

Optional Feature:
- FIFO_WARB_STATS_EN defined:
  - Adds outputs stat_words (NUM_REQ*16) and stat_stalls (16).
  - stat_words[i] counts transferred words of requester i, saturating at 16'hFFFF.
  - stat_stalls counts BURST cycles with req[owner]&&!space, saturating.
  - All stats clear on hw_rst or sw_rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then single requester: req[0]=1 with 3 words, last on the 3rd, wr_level=0 -> gnt[0] high cycles 1-3, write_enable high cycles 2-4 with matching data, then IDLE, rr pointer=1.
- All 4 req continuously, MAX_BURST=8, no last -> owners 0,1,2,3,0 in turn, each exactly 8 writes, 1 idle cycle between bursts.
- Space throttle: wr_level=31, write_enable=1 -> gnt=0 that cycle; hold wr_level=32/wfull=1 for 5 cycles -> no write_enable, count frozen; release -> burst resumes at the same word.
- Mid-burst sw_rst after 2 of 6 words -> next cycle write_enable=0, gnt=0, IDLE; with req[2] and req[0] pending, requester 0 is granted next.
- afull_cfg changed 20->12 during BURST -> afull_value stays 20 until the IDLE cycle, then 12.
- Async reset mid-burst (hw_rst low between edges) -> all outputs immediately at reset values, afull_value=20; with FIFO_WARB_STATS_EN, stats read 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters (wclk domain).
// Define FIFO_WARB_STATS_EN to add per-requester word counters and a stall counter.
module fifo_write_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_W        = 32,
   parameter int FIFO_DEPTH    = 32,
   parameter int MAX_BURST     = 8,
   parameter int AFULL_DEFAULT = 20
) (
   input  logic                         wclk,
   input  logic                         hw_rst,
   input  logic                         sw_rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           gnt,
   input  logic [4:0]                   afull_cfg,
   input  logic                         wfull,
   input  logic [5:0]                   wr_level,
   output logic [DATA_W-1:0]            wdata,
   output logic                         write_enable,
   output logic [4:0]                   afull_value,
   output logic [$clog2(NUM_REQ)-1:0]   owner,
   output logic                         busy
`ifdef FIFO_WARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]        stat_words,
   output logic [15:0]                  stat_stalls
`endif
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAXB  = CW'(MAX_BURST);
   localparam logic [6:0]    DEPTH = 7'(FIFO_DEPTH);

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state;
   logic [OW-1:0]       rr_ptr;
   logic [OW-1:0]       pick;
   logic [OW-1:0]       rr_nxt;
   logic [CW-1:0]       count;
   logic [CW-1:0]       cnt_inc;
   logic [6:0]          lvl_sum;
   logic                space;
   logic                xfer;
   logic [DATA_W-1:0]   owner_data;

   // The word sitting in the output register counts against capacity too.
   assign lvl_sum    = {1'b0, wr_level} + {6'b0, write_enable};
   assign space      = !wfull && (lvl_sum < DEPTH);
   assign busy       = (state == BURST);
   assign xfer       = busy && req[owner] && space;
   assign owner_data = req_data[owner*DATA_W +: DATA_W];
   assign cnt_inc    = count + 1'b1;
   assign rr_nxt     = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   // Scan downward so the lowest offset from rr_ptr wins.
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr) + k) % NUM_REQ])
            pick = OW'((int'(rr_ptr) + k) % NUM_REQ);
      end
   end

   always_comb begin
      gnt = '0;
      if (busy)
         gnt[owner] = space;
   end

   always_ff @(posedge wclk or negedge hw_rst) begin
      if (!hw_rst) begin
         state        <= IDLE;
         write_enable <= 1'b0;
         wdata        <= '0;
         owner        <= '0;
         afull_value  <= 5'(AFULL_DEFAULT);
         rr_ptr       <= '0;
         count        <= '0;
      end else if (sw_rst) begin
         state        <= IDLE;
         write_enable <= 1'b0;
         count        <= '0;
         rr_ptr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               write_enable <= 1'b0;
               afull_value  <= afull_cfg;
               if (|req) begin
                  owner <= pick;
                  count <= '0;
                  state <= BURST;
               end
            end
            BURST: begin
               if (xfer) begin
                  wdata        <= owner_data;
                  write_enable <= 1'b1;
                  count        <= cnt_inc;
                  if (req_last[owner] || (cnt_inc == MAXB)) begin
                     state  <= IDLE;
                     rr_ptr <= rr_nxt;
                  end
               end else begin
                  write_enable <= 1'b0;
                  // A requester that drops valid while it could have written gives up the port.
                  if (!req[owner] && space) begin
                     state  <= IDLE;
                     rr_ptr <= rr_nxt;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_WARB_STATS_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      always_ff @(posedge wclk or negedge hw_rst) begin
         if (!hw_rst)
            stat_words[i*16 +: 16] <= '0;
         else if (sw_rst)
            stat_words[i*16 +: 16] <= '0;
         else if (xfer && (owner == OW'(i)) && (stat_words[i*16 +: 16] != 16'hFFFF))
            stat_words[i*16 +: 16] <= stat_words[i*16 +: 16] + 1'b1;
      end
   end

   always_ff @(posedge wclk or negedge hw_rst) begin
      if (!hw_rst)
         stat_stalls <= '0;
      else if (sw_rst)
         stat_stalls <= '0;
      else if (busy && req[owner] && !space && (stat_stalls != 16'hFFFF))
         stat_stalls <= stat_stalls + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, directed corner sequences, randomized run vs. reference model.
module tb_fifo_write_arbiter;
   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int MAXB = 8;

   logic              wclk = 1'b0;
   logic              hw_rst = 1'b0;
   logic              sw_rst = 1'b0;
   logic [N-1:0]      req = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic [N-1:0]      req_last = '0;
   logic [N-1:0]      gnt;
   logic [4:0]        afull_cfg = 5'd20;
   logic              wfull = 1'b0;
   logic [5:0]        wr_level = '0;
   logic [DW-1:0]     wdata;
   logic              write_enable;
   logic [4:0]        afull_value;
   logic [1:0]        owner;
   logic              busy;
`ifdef FIFO_WARB_STATS_EN
   logic [N*16-1:0]   stat_words;
   logic [15:0]       stat_stalls;
`endif

   fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FIFO_DEPTH(32), .MAX_BURST(MAXB), .AFULL_DEFAULT(20)) dut (
      .wclk(wclk), .hw_rst(hw_rst), .sw_rst(sw_rst), .req(req), .req_data(req_data),
      .req_last(req_last), .gnt(gnt), .afull_cfg(afull_cfg), .wfull(wfull), .wr_level(wr_level),
      .wdata(wdata), .write_enable(write_enable), .afull_value(afull_value), .owner(owner), .busy(busy)
`ifdef FIFO_WARB_STATS_EN
      , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
   );

   always #5 wclk = ~wclk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge wclk);
      #1;
   endtask

   task automatic settle();
      @(negedge wclk);
   endtask

   task automatic set_data(input logic [31:0] d);
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      hw_rst = 1'b0; sw_rst = 1'b0; req = '0; req_last = '0;
      wfull = 1'b0; wr_level = '0; afull_cfg = 5'd20; set_data('0);
      repeat (2) @(posedge wclk);
      #1 hw_rst = 1'b1;
   endtask

   // Reference model: tracks who owns the port, how many words the burst has moved,
   // and where the next round-robin search starts; evaluated on the same edges as the DUT.
   bit         m_busy = 0, m_we = 0;
   logic [31:0] m_wd = '0;
   int         m_own = 0, m_rr = 0, m_cnt = 0;
   logic [4:0] m_af = 5'd20;

   function automatic bit room(input bit staged);
      return !wfull && (int'(wr_level) + int'(staged) < 32);
   endfunction

   always @(posedge wclk or negedge hw_rst) begin
      if (!hw_rst) begin
         m_busy = 0; m_we = 0; m_wd = '0; m_own = 0; m_rr = 0; m_cnt = 0; m_af = 5'd20;
      end else if (sw_rst) begin
         m_busy = 0; m_we = 0; m_cnt = 0; m_rr = 0;
      end else if (!m_busy) begin
         m_we = 0;
         m_af = afull_cfg;
         for (int k = 0; k < N; k++) begin
            if (!m_busy && req[(m_rr + k) % N]) begin
               m_own = (m_rr + k) % N; m_busy = 1; m_cnt = 0;
            end
         end
      end else begin
         bit sp;
         sp = room(m_we);
         if (req[m_own] && sp) begin
            m_we = 1; m_wd = req_data[m_own*DW +: DW]; m_cnt++;
            if (req_last[m_own] || m_cnt == MAXB) begin
               m_busy = 0; m_rr = (m_own + 1) % N;
            end
         end else begin
            m_we = 0;
            if (!req[m_own] && sp) begin
               m_busy = 0; m_rr = (m_own + 1) % N;
            end
         end
      end
   end

   typedef struct {
      logic [3:0]  rq;
      logic [3:0]  lst;
      logic [31:0] d;
      logic [3:0]  e_gnt;
      logic        e_we;
      logic [31:0] e_wd;
      logic        e_busy;
      logic [1:0]  e_own;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [3:0] eg;
      logic [3:0] prev_gnt;
      logic [1:0] mo;

      tbl[0]  = '{4'h1, 4'h0, 32'hA000_0000, 4'h0, 1'b0, 32'h0,          1'b0, 2'd0};
      tbl[1]  = '{4'h1, 4'h0, 32'hA000_0000, 4'h1, 1'b0, 32'h0,          1'b1, 2'd0};
      tbl[2]  = '{4'h1, 4'h0, 32'hA000_0001, 4'h1, 1'b1, 32'hA000_0000, 1'b1, 2'd0};
      tbl[3]  = '{4'h1, 4'h1, 32'hA000_0002, 4'h1, 1'b1, 32'hA000_0001, 1'b1, 2'd0};
      tbl[4]  = '{4'h0, 4'h0, 32'h0,          4'h0, 1'b1, 32'hA000_0002, 1'b0, 2'd0};
      tbl[5]  = '{4'h0, 4'h0, 32'h0,          4'h0, 1'b0, 32'hA000_0002, 1'b0, 2'd0};
      tbl[6]  = '{4'h3, 4'h0, 32'h0,          4'h0, 1'b0, 32'hA000_0002, 1'b0, 2'd0};
      tbl[7]  = '{4'h0, 4'h0, 32'h0,          4'h2, 1'b0, 32'hA000_0002, 1'b1, 2'd1};
      tbl[8]  = '{4'h0, 4'h0, 32'h0,          4'h0, 1'b0, 32'hA000_0002, 1'b0, 2'd1};
      tbl[9]  = '{4'h3, 4'h0, 32'h0,          4'h0, 1'b0, 32'hA000_0002, 1'b0, 2'd1};
      tbl[10] = '{4'h0, 4'h0, 32'h0,          4'h1, 1'b0, 32'hA000_0002, 1'b1, 2'd0};
      tbl[11] = '{4'h0, 4'h0, 32'h0,          4'h0, 1'b0, 32'hA000_0002, 1'b0, 2'd0};

      // Reset state
      do_reset();
      settle();
      chk("rst_we", write_enable, 0); chk("rst_wdata", wdata, 0); chk("rst_gnt", gnt, 0);
      chk("rst_owner", owner, 0); chk("rst_busy", busy, 0); chk("rst_afull", afull_value, 20);

      // Single-requester burst and round-robin pointer movement
      for (int r = 0; r < 12; r++) begin
         next_cyc();
         req = tbl[r].rq; req_last = tbl[r].lst; set_data(tbl[r].d);
         settle();
         chk($sformatf("vec%0d_gnt", r), gnt, tbl[r].e_gnt);
         chk($sformatf("vec%0d_we", r), write_enable, tbl[r].e_we);
         chk($sformatf("vec%0d_wdata", r), wdata, tbl[r].e_wd);
         chk($sformatf("vec%0d_busy", r), busy, tbl[r].e_busy);
         chk($sformatf("vec%0d_owner", r), owner, tbl[r].e_own);
      end
`ifdef FIFO_WARB_STATS_EN
      chk("stat_words0", stat_words[15:0], 3);
`endif

      // All requesters continuously: 8-word bursts, one idle cycle, owners rotate
      do_reset();
      next_cyc(); req = 4'hF; settle();
      chk("rr_gnt0", gnt, 0);
      prev_gnt = gnt;
      for (int c = 1; c < 45; c++) begin
         next_cyc(); settle();
         eg = (c % 9 == 0) ? 4'h0 : 4'(1 << ((c / 9) % 4));
         chk($sformatf("rr_gnt%0d", c), gnt, eg);
         chk($sformatf("rr_we%0d", c), write_enable, (prev_gnt != 0));
         prev_gnt = gnt;
      end

      // Space throttle: staged word plus level hits depth, then full for 5 cycles
      do_reset();
      next_cyc(); req = 4'h1; set_data(32'h5000_0000); settle();
      next_cyc(); settle();
      chk("thr_gnt_start", gnt, 4'h1);
      next_cyc(); wr_level = 6'd31; set_data(32'h5000_0001); settle();
      chk("thr_we_staged", write_enable, 1);
      chk("thr_gnt_31", gnt, 0);
      for (int k = 0; k < 5; k++) begin
         next_cyc(); wr_level = 6'd32; wfull = 1'b1; settle();
         chk($sformatf("thr_full_gnt%0d", k), gnt, 0);
         chk($sformatf("thr_full_we%0d", k), write_enable, 0);
      end
      next_cyc(); wr_level = 6'd0; wfull = 1'b0; settle();
      chk("thr_resume_gnt", gnt, 4'h1);
      next_cyc(); settle();
      chk("thr_resume_we", write_enable, 1);
      chk("thr_resume_wdata", wdata, 32'h5000_0001);
`ifdef FIFO_WARB_STATS_EN
      chk("thr_stalls", stat_stalls, 6);
`endif

      // sw_rst mid-burst restarts the round-robin search at requester 0
      do_reset();
      next_cyc(); req = 4'h1; req_last = 4'h1; settle();
      next_cyc(); settle();
      chk("swr_first_gnt", gnt, 4'h1);
      next_cyc(); req = 4'h4; req_last = 4'h0; settle();
      next_cyc(); settle();
      chk("swr_owner2", owner, 2);
      chk("swr_gnt2", gnt, 4'h4);
      next_cyc(); settle();
      chk("swr_we_mid", write_enable, 1);
      next_cyc(); sw_rst = 1'b1; req = 4'h5; settle();
      next_cyc(); sw_rst = 1'b0; settle();
      chk("swr_we", write_enable, 0); chk("swr_gnt", gnt, 0);
      chk("swr_busy", busy, 0); chk("swr_owner_kept", owner, 2);
      next_cyc(); settle();
      chk("swr_next_owner", owner, 0); chk("swr_next_gnt", gnt, 4'h1);

      // afull threshold only follows afull_cfg while idle
      do_reset();
      next_cyc(); req = 4'h1; settle();
      next_cyc(); afull_cfg = 5'd12; settle();
      chk("af_busy", busy, 1); chk("af_burst0", afull_value, 20);
      next_cyc(); settle();
      chk("af_burst1", afull_value, 20);
      next_cyc(); req = 4'h0; settle();
      chk("af_burst2", afull_value, 20);
      next_cyc(); settle();
      chk("af_idle_busy", busy, 0); chk("af_idle", afull_value, 20);
      next_cyc(); settle();
      chk("af_loaded", afull_value, 12);

      // Asynchronous reset between edges during a burst
      next_cyc(); req = 4'h2; set_data(32'hDEAD_BEEF); settle();
      next_cyc(); settle();
      chk("ar_gnt_pre", gnt, 4'h2);
      next_cyc(); settle();
      chk("ar_we_pre", write_enable, 1);
      #2 hw_rst = 1'b0;
      #1;
      chk("ar_we", write_enable, 0); chk("ar_wdata", wdata, 0); chk("ar_gnt", gnt, 0);
      chk("ar_owner", owner, 0); chk("ar_busy", busy, 0); chk("ar_afull", afull_value, 20);
`ifdef FIFO_WARB_STATS_EN
      chk("ar_stat_words", stat_words, 0); chk("ar_stat_stalls", stat_stalls, 0);
`endif

      // Randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         next_cyc();
         req = 4'($urandom) | 4'($urandom);
         req_last = 4'($urandom) & 4'($urandom);
         for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
         wr_level = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 29)) : 6'($urandom_range(29, 32));
         wfull = (wr_level == 6'd32) || ($urandom_range(0, 15) == 0);
         sw_rst = ($urandom_range(0, 39) == 0);
         afull_cfg = 5'($urandom);
         settle();
         eg = '0;
         if (m_busy && room(m_we)) eg[m_own] = 1'b1;
         mo = m_own[1:0];
         chk($sformatf("rnd%0d_gnt", c), gnt, eg);
         chk($sformatf("rnd%0d_we", c), write_enable, m_we);
         chk($sformatf("rnd%0d_wdata", c), wdata, m_wd);
         chk($sformatf("rnd%0d_afull", c), afull_value, m_af);
         chk($sformatf("rnd%0d_owner", c), owner, mo);
         chk($sformatf("rnd%0d_busy", c), busy, m_busy);
      end
      sw_rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
